// File: rtl/main_memory_responder_pkg.sv
// main_memory_responder_pkg
// Shared definitions for the backing-store responder and the cache data/tag logic.
// - mem_state_e : responder FSM state encoding
// - BLK_W, OFFSET_W, INDEX_W : block geometry constants
// - merge_lane() : replace one byte lane of a block
package main_memory_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mem_state_e;

  localparam int BLK_W    = 64;
  localparam int OFFSET_W = 3;
  localparam int INDEX_W  = 6;

  // Lane 0 is bits [7:0]; every other lane is passed through unchanged.
  function automatic logic [BLK_W-1:0] merge_lane(
    input logic [BLK_W-1:0]    blk,
    input logic [OFFSET_W-1:0] lane,
    input logic [7:0]          wbyte
  );
    logic [BLK_W-1:0] res;
    res = blk;
    res[{lane, 3'b000} +: 8] = wbyte;
    return res;
  endfunction

endpackage

// File: rtl/main_memory_responder_counter.sv
// mem_latency_counter
// Access-latency down-counter for the responder FSM.
// Ports:
//   clk_i   : rising-edge clock
//   rst_i   : asynchronous active-high reset (count -> 0)
//   load_i  : load LATENCY-1 (request accepted)
//   dec_i   : decrement while non-zero (request in flight)
//   zero_o  : count is zero (completion edge when a request is in flight)
module mem_latency_counter
  import main_memory_responder_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder
// Backing store for the cache refill path. Serves 64-bit block reads and
// write-through byte writes, one request at a time, each completing a fixed
// LATENCY edges after acceptance.
// Ports:
//   clk_i          : rising-edge clock
//   rst_i          : asynchronous active-high reset (storage is not reset)
//   rd_req_i       : block read request, held until accepted
//   rd_blk_addr_i  : block address (byte address >> 3)
//   wr_req_i       : byte write request, held until accepted
//   wr_addr_i      : byte address, [2:0] selects the lane (lane 0 = bits [7:0])
//   wr_data_i      : write byte
//   busy_o         : request in flight, new requests ignored
//   data_block_o   : last block read, valid with data_ready_o, held otherwise
//   data_ready_o   : one-cycle read completion pulse
//   wr_done_o      : one-cycle write commit pulse
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_req_i,
  input  logic [ADDR_W-4:0]      rd_blk_addr_i,
  input  logic                   wr_req_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [7:0]             wr_data_i,
  output logic                   busy_o,
  output logic [BLK_W-1:0]       data_block_o,
  output logic                   data_ready_o,
  output logic                   wr_done_o
);

  localparam int BLK_AW = ADDR_W - OFFSET_W;
  localparam int DEPTH  = 1 << BLK_AW;

  mem_state_e            state_q;
  logic [BLK_AW-1:0]     blk_addr_q;
  logic [OFFSET_W-1:0]   lane_q;
  logic [7:0]            wbyte_q;
  logic                  busy_q;
  logic                  data_ready_q;
  logic                  wr_done_q;
  logic [BLK_W-1:0]      data_block_q;

  logic [BLK_W-1:0]      mem_q [DEPTH];
  logic [BLK_W-1:0]      merged_blk_d;

  logic                  accept;
  logic                  cnt_zero;

  assign accept = (state_q == ST_IDLE) && (rd_req_i || wr_req_i);

  mem_latency_counter #(
    .LATENCY (LATENCY)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .dec_i  (state_q != ST_IDLE),
    .zero_o (cnt_zero)
  );

  assign merged_blk_d = merge_lane(mem_q[blk_addr_q], lane_q, wbyte_q);

  // Storage has no reset. A write in flight when rst asserts never commits,
  // because rst forces state_q to IDLE before any further edge.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_WR_WAIT) && cnt_zero) begin
      mem_q[blk_addr_q] <= merged_blk_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      blk_addr_q   <= '0;
      lane_q       <= '0;
      wbyte_q      <= '0;
      busy_q       <= 1'b0;
      data_ready_q <= 1'b0;
      wr_done_q    <= 1'b0;
      data_block_q <= '0;
    end else begin
      data_ready_q <= 1'b0;
      wr_done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Write wins a tie so a read of the same block sees the new byte.
          if (wr_req_i) begin
            blk_addr_q <= wr_addr_i[ADDR_W-1:OFFSET_W];
            lane_q     <= wr_addr_i[OFFSET_W-1:0];
            wbyte_q    <= wr_data_i;
            busy_q     <= 1'b1;
            state_q    <= ST_WR_WAIT;
          end else if (rd_req_i) begin
            blk_addr_q <= rd_blk_addr_i;
            busy_q     <= 1'b1;
            state_q    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (cnt_zero) begin
            data_block_q <= mem_q[blk_addr_q];
            data_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        ST_WR_WAIT: begin
          if (cnt_zero) begin
            wr_done_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign data_ready_o = data_ready_q;
  assign wr_done_o    = wr_done_q;
  assign data_block_o = data_block_q;

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [8:0]  rd_blk_addr;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  int          sel;   // 0: LATENCY=4 instance, 1: LATENCY=1 instance

  logic        busy4, rdy4, wrd4, busy1, rdy1, wrd1;
  logic [63:0] blk4, blk1;
  logic        busy, data_ready, wr_done;
  logic [63:0] data_block;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: whole blocks as plain arrays, last read block per instance.
  logic [63:0] ref_mem [2][512];
  logic [63:0] ref_blk [2];

  always #5 clk = ~clk;

  main_memory_responder #(.ADDR_W(ADDR_W), .LATENCY(4), .INIT_FILE("")) dut4 (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req && sel == 0), .rd_blk_addr_i(rd_blk_addr),
    .wr_req_i(wr_req && sel == 0), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy4), .data_block_o(blk4), .data_ready_o(rdy4), .wr_done_o(wrd4)
  );

  main_memory_responder #(.ADDR_W(ADDR_W), .LATENCY(1), .INIT_FILE("")) dut1 (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req && sel == 1), .rd_blk_addr_i(rd_blk_addr),
    .wr_req_i(wr_req && sel == 1), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy1), .data_block_o(blk1), .data_ready_o(rdy1), .wr_done_o(wrd1)
  );

  assign busy       = (sel == 1) ? busy1 : busy4;
  assign data_ready = (sel == 1) ? rdy1  : rdy4;
  assign wr_done    = (sel == 1) ? wrd1  : wrd4;
  assign data_block = (sel == 1) ? blk1  : blk4;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transaction, entered at a negedge with the selected DUT idle.
  // Expect acceptance at the next edge, busy for LATENCY cycles, then a
  // one-cycle completion pulse. keep_rd leaves rd_req high across a write;
  // poke raises a stray rd_req for one cycle while busy.
  task automatic txn(input bit is_wr, input logic [11:0] addr, input logic [7:0] d,
                     input int gap, input bit keep_rd, input bit poke);
    int L = (sel == 1) ? 1 : 4;
    int s = sel;
    logic [63:0] tmp;
    if (is_wr) begin
      wr_req = 1'b1; wr_addr = addr; wr_data = d;
      if (keep_rd) begin rd_req = 1'b1; rd_blk_addr = addr[11:3]; end
    end else begin
      rd_req = 1'b1; rd_blk_addr = addr[11:3];
    end
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      if (k == 0) begin
        wr_req = 1'b0;
        if (!keep_rd) rd_req = 1'b0;
      end
      check_eq("busy_in_flight", busy, 1'b1);
      check_eq("no_early_ready", data_ready, 1'b0);
      check_eq("no_early_wrdone", wr_done, 1'b0);
      if (poke && k == 1) begin rd_req = 1'b1; rd_blk_addr = ~addr[11:3]; end
      if (poke && k == 2) rd_req = 1'b0;
    end
    @(negedge clk);
    check_eq("busy_released", busy, 1'b0);
    if (is_wr) begin
      tmp = ref_mem[s][addr[11:3]];
      tmp[8*int'(addr[2:0]) +: 8] = d;
      ref_mem[s][addr[11:3]] = tmp;
      check_eq("wr_done_pulse", wr_done, 1'b1);
      check_eq("no_ready_on_write", data_ready, 1'b0);
      check_eq("block_held", data_block, ref_blk[s]);
    end else begin
      ref_blk[s] = ref_mem[s][addr[11:3]];
      check_eq("data_ready_pulse", data_ready, 1'b1);
      check_eq("no_wrdone_on_read", wr_done, 1'b0);
      check_eq("read_data", data_block, ref_blk[s]);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check_eq("idle_no_ready", data_ready, 1'b0);
      check_eq("idle_no_wrdone", wr_done, 1'b0);
      check_eq("idle_not_busy", busy, 1'b0);
      check_eq("idle_block_held", data_block, ref_blk[s]);
    end
  endtask

  // Start a request, then assert rst asynchronously while it is in flight.
  task automatic reset_mid(input bit is_wr, input logic [11:0] addr, input logic [7:0] d);
    if (is_wr) begin wr_req = 1'b1; wr_addr = addr; wr_data = d; end
    else begin rd_req = 1'b1; rd_blk_addr = addr[11:3]; end
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    check_eq("rst_pre_busy", busy, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_busy", busy, 1'b0);
    check_eq("rst_async_ready", data_ready, 1'b0);
    check_eq("rst_async_wrdone", wr_done, 1'b0);
    check_eq("rst_async_block", data_block, 64'd0);
    ref_blk[0] = 64'd0;
    ref_blk[1] = 64'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 7; g++) begin
      @(negedge clk);
      check_eq("rst_no_ready", data_ready, 1'b0);
      check_eq("rst_no_wrdone", wr_done, 1'b0);
      check_eq("rst_idle", busy, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (n_checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pat;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rd_blk_addr = '0;
    wr_addr = '0; wr_data = '0; sel = 0;
    ref_blk[0] = 64'd0; ref_blk[1] = 64'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy4", busy4, 1'b0);
    check_eq("reset_ready4", rdy4, 1'b0);
    check_eq("reset_wrdone4", wrd4, 1'b0);
    check_eq("reset_block4", blk4, 64'd0);
    check_eq("reset_busy1", busy1, 1'b0);
    check_eq("reset_block1", blk1, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Preload blocks 0..15 of the LATENCY=4 instance byte by byte.
    for (int b = 0; b < 16; b++) begin
      pat = (b == 5) ? 64'h8877665544332211 : {$urandom, $urandom};
      for (int l = 0; l < 8; l++)
        txn(1'b1, 12'(b * 8 + l), pat[8*l +: 8], 0, 1'b0, 1'b0);
    end

    txn(1'b0, 12'h028, 8'h00, 1, 1'b0, 1'b0);
    check_eq("basic_read_const", data_block, 64'h8877665544332211);
    txn(1'b1, 12'h02B, 8'hAB, 1, 1'b0, 1'b0);
    txn(1'b0, 12'h028, 8'h00, 1, 1'b0, 1'b0);
    check_eq("write_then_read_const", data_block, 64'h88776655AB332211);

    // Simultaneous write and read of block 5: write first, then merged read.
    txn(1'b1, 12'h02E, 8'h5A, 0, 1'b1, 1'b0);
    txn(1'b0, 12'h028, 8'h00, 1, 1'b0, 1'b0);
    check_eq("simul_merged_const", data_block, 64'h885A6655AB332211);

    // Stray one-cycle read while busy must never complete.
    txn(1'b0, 12'h010, 8'h00, 8, 1'b0, 1'b1);

    reset_mid(1'b0, 12'h028, 8'h00);
    txn(1'b0, 12'h028, 8'h00, 1, 1'b0, 1'b0);
    reset_mid(1'b1, 12'h028, 8'hEE);
    txn(1'b0, 12'h028, 8'h00, 1, 1'b0, 1'b0);
    check_eq("dropped_write_const", data_block, 64'h885A6655AB332211);

    for (int i = 0; i < 150; i++) begin
      txn(1'($urandom_range(0, 1)), 12'($urandom_range(0, 127)), 8'($urandom),
          $urandom_range(0, 2), 1'b0, ($urandom_range(0, 7) == 0));
    end

    // LATENCY=1 instance: preload blocks 0..2, then held back-to-back reads.
    sel = 1;
    for (int b = 0; b < 3; b++) begin
      pat = {$urandom, $urandom};
      for (int l = 0; l < 8; l++)
        txn(1'b1, 12'(b * 8 + l), pat[8*l +: 8], 0, 1'b0, 1'b0);
    end
    for (int r = 0; r < 6; r++)
      txn(1'b0, 12'((r % 3) * 8), 8'h00, 0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom_range(0, 1)), 12'($urandom_range(0, 23)), 8'($urandom),
          $urandom_range(0, 1), 1'b0, 1'b0);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
